// File: rtl/regex_pc_split_fifo.sv
// -----------------------------------------------------------------------------
// regex_pc_split_fifo
//
// Dual-push / single-pop PC buffer between the regex CPU execute stage and its
// output port. A SPLIT produces two successor PCs (pc+1 and the branch target)
// in one cycle. Both are absorbed in that cycle and drained one per cycle.
//
// Handshake:
//   Input side: a push is taken only when in_ready is high. in_ready is
//     derived from registered occupancy only, so it never depends on out_ready.
//     While in_ready is low the producer holds its inputs and nothing changes.
//   Output side: out_valid/out_ready. The head entry is consumed on a cycle
//     where both are high. While out_valid is high and out_ready is low, out_pc
//     and out_cc_id are held stable.
//
// Parameters:
//   PC_WIDTH              width of a program counter
//   CC_ID_BITS            width of the character-channel id tag
//   FIFO_WIDTH_POWER_OF_2 log2 of depth (DEPTH = 2**FIFO_WIDTH_POWER_OF_2, >= 2)
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   in0_valid/pc/cc_id        slot 0 (fall-through, pc+1), written first
//   in1_valid/pc/cc_id        slot 1 (split target), written after slot 0
//   in_ready                  at least two free entries
//   out_valid/pc/cc_id        head of FIFO (first-word fall-through)
//   out_ready                 consumer takes the head this cycle
//   occupancy                 number of stored entries
//   running                   occupancy != 0 or any input slot valid
//
// Configuration macro:
//   REGEX_SPLIT_DEDUP_EN      when defined, a dual push of two identical
//                             (pc, cc_id) pairs stores only slot 0.
// -----------------------------------------------------------------------------
module regex_pc_split_fifo #(
    parameter int PC_WIDTH              = 9,
    parameter int CC_ID_BITS            = 2,
    parameter int FIFO_WIDTH_POWER_OF_2 = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in0_valid,
    input  logic [PC_WIDTH-1:0]              in0_pc,
    input  logic [CC_ID_BITS-1:0]            in0_cc_id,
    input  logic                             in1_valid,
    input  logic [PC_WIDTH-1:0]              in1_pc,
    input  logic [CC_ID_BITS-1:0]            in1_cc_id,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic [PC_WIDTH-1:0]              out_pc,
    output logic [CC_ID_BITS-1:0]            out_cc_id,
    input  logic                             out_ready,
    output logic [FIFO_WIDTH_POWER_OF_2:0]   occupancy,
    output logic                             running
);

    localparam int AW    = FIFO_WIDTH_POWER_OF_2;
    localparam int DEPTH = 1 << AW;
    localparam int EW    = PC_WIDTH + CC_ID_BITS;
    // in_ready threshold: at most DEPTH-2 entries stored leaves room for two.
    localparam logic [AW:0] READY_LIMIT = (AW+1)'(DEPTH - 2);

    // Entry layout: {cc_id, pc}
    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   occ;

    logic          dup;
    logic          wr0;
    logic          wr1;
    logic [AW-1:0] wr1_addr;
    logic [AW:0]   n_push;
    logic          pop;

`ifdef REGEX_SPLIT_DEDUP_EN
    // A SPLIT whose target equals pc+1 would otherwise queue the same thread twice.
    assign dup = in0_valid & in1_valid & (in0_pc == in1_pc) & (in0_cc_id == in1_cc_id);
`else
    assign dup = 1'b0;
`endif

    assign in_ready = (occ <= READY_LIMIT);
    assign wr0      = in_ready & in0_valid;
    assign wr1      = in_ready & in1_valid & ~dup;
    // Slot 1 lands right after slot 0, or at wr_ptr itself when slot 0 is idle.
    assign wr1_addr = wr_ptr + AW'(wr0);
    assign n_push   = (AW+1)'(wr0) + (AW+1)'(wr1);
    assign pop      = (occ != '0) & out_ready;

    // Storage carries no reset; contents are only visible when out_valid is high.
    always_ff @(posedge clk) begin
        if (wr0) mem[wr_ptr]   <= {in0_cc_id, in0_pc};
        if (wr1) mem[wr1_addr] <= {in1_cc_id, in1_pc};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
            wr_ptr <= wr_ptr + n_push[AW-1:0];
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            occ    <= occ + n_push - (AW+1)'(pop);
        end
    end

    assign out_valid = (occ != '0);
    assign out_pc    = mem[rd_ptr][PC_WIDTH-1:0];
    assign out_cc_id = mem[rd_ptr][EW-1:PC_WIDTH];
    assign occupancy = occ;
    assign running   = (occ != '0) | in0_valid | in1_valid;

endmodule
